// File: rtl/mdu_e.sv
// mdu_e: execute-stage multiply/divide unit owning the HI/LO registers.
// Latency: MULT/MULTU/MTHI/MTLO write at the next edge; DIV/DIVU stall WIDTH+1 cycles, result visible after FIX.
// Backpressure: StallMD holds the pipeline while a divide is in flight; FlushE/reset cancel it immediately.
// Optional feature: define MDU_DIVZERO_FAST_EN to skip the RUN sequence for a zero divisor.
module mdu_e #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             StartE,
  input  logic [2:0]       MDOpE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  input  logic             FlushE,
  output logic [WIDTH-1:0] HiE,
  output logic [WIDTH-1:0] LoE,
  output logic             StallMD,
  output logic             DoneE
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend magnitude, shifted out while quotient bits shift in
  logic [WIDTH-1:0] dvs_q, dvs_d;   // divisor magnitude
  logic [WIDTH-1:0] rem_q, rem_d;   // partial remainder magnitude
  logic             qs_q, qs_d;     // quotient sign
  logic             rs_q, rs_d;     // remainder sign

  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic [WIDTH:0]     trial_sh, trial_df;
  logic               is_signed_div;
  logic [WIDTH-1:0]   a_mag, b_mag;

  assign prod_s = $signed({{WIDTH{SrcAE[WIDTH-1]}}, SrcAE}) * $signed({{WIDTH{SrcBE[WIDTH-1]}}, SrcBE});
  assign prod_u = {{WIDTH{1'b0}}, SrcAE} * {{WIDTH{1'b0}}, SrcBE};

  // Restoring step: bring the next dividend bit into the remainder and try subtracting the divisor.
  assign trial_sh = {rem_q, dvd_q[WIDTH-1]};
  assign trial_df = trial_sh - {1'b0, dvs_q};

  assign is_signed_div = (MDOpE == OP_DIV);
  assign a_mag = (is_signed_div && SrcAE[WIDTH-1]) ? -SrcAE : SrcAE;
  assign b_mag = (is_signed_div && SrcBE[WIDTH-1]) ? -SrcBE : SrcBE;

  assign HiE = hi_q;
  assign LoE = lo_q;

  // Next-state and output logic; flush overrides everything and leaves HI/LO alone.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    qs_d    = qs_q;
    rs_d    = rs_q;
    StallMD = 1'b0;
    DoneE   = 1'b0;
    if (FlushE) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (StartE) begin
            case (MDOpE)
              OP_MULT:  {hi_d, lo_d} = prod_s;
              OP_MULTU: {hi_d, lo_d} = prod_u;
              OP_MTHI:  hi_d = SrcAE;
              OP_MTLO:  lo_d = SrcAE;
              OP_DIV, OP_DIVU: begin
                dvd_d   = a_mag;
                dvs_d   = b_mag;
                qs_d    = is_signed_div && (SrcAE[WIDTH-1] ^ SrcBE[WIDTH-1]);
                rs_d    = is_signed_div && SrcAE[WIDTH-1];
                rem_d   = '0;
                cnt_d   = '0;
                StallMD = 1'b1;
                state_d = RUN;
`ifdef MDU_DIVZERO_FAST_EN
                // A zero divisor yields an all-ones quotient and the dividend as remainder.
                if (SrcBE == '0) begin
                  dvd_d   = '1;
                  rem_d   = a_mag;
                  state_d = FIX;
                end
`endif
              end
              default: ;
            endcase
          end
        end
        RUN: begin
          StallMD = 1'b1;
          rem_d   = trial_df[WIDTH] ? trial_sh[WIDTH-1:0] : trial_df[WIDTH-1:0];
          dvd_d   = {dvd_q[WIDTH-2:0], ~trial_df[WIDTH]};
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH-1)) begin
            state_d = FIX;
            cnt_d   = '0;
          end
        end
        FIX: begin
          DoneE   = 1'b1;
          lo_d    = qs_q ? -dvd_q : dvd_q;
          hi_d    = rs_q ? -rem_q : rem_q;
          state_d = IDLE;
          cnt_d   = '0;
        end
        default: state_d = IDLE;
      endcase
    end
    if (reset) begin
      StallMD = 1'b0;
      DoneE   = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      qs_q    <= 1'b0;
      rs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      qs_q    <= qs_d;
      rs_q    <= rs_d;
    end
  end

endmodule

// File: tb/tb_mdu_e.sv
// Scoreboard bench for mdu_e: expected HI/LO pushed at issue, monitor compares on DoneE or observe points.
module tb_mdu_e;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

`ifdef MDU_DIVZERO_FAST_EN
  localparam int ZERO_STALL = 1;
`else
  localparam int ZERO_STALL = 33;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        StartE = 1'b0;
  logic [2:0]  MDOpE = 3'b000;
  logic [31:0] SrcAE = '0;
  logic [31:0] SrcBE = '0;
  logic        FlushE = 1'b0;
  logic [31:0] HiE, LoE;
  logic        StallMD, DoneE;

  mdu_e #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .StartE(StartE), .MDOpE(MDOpE),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .FlushE(FlushE),
    .HiE(HiE), .LoE(LoE), .StallMD(StallMD), .DoneE(DoneE)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   done_cnt = 0;
  logic obs = 1'b0;
  logic done_d = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic push(input string name, input logic [31:0] hi, input logic [31:0] lo);
    exp_t e;
    e.name = name; e.hi = hi; e.lo = lo;
    sb.push_back(e);
  endtask

  task automatic idle_in();
    StartE = 1'b0; MDOpE = 3'b000; FlushE = 1'b0;
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic fl);
    @(posedge clock); #1;
    StartE = 1'b1; MDOpE = op; SrcAE = a; SrcBE = b; FlushE = fl;
  endtask

  task automatic observe();
    @(posedge clock); #1;
    idle_in();
    obs = 1'b1;
    @(negedge clock); #1;
    obs = 1'b0;
  endtask

  // Single-cycle ops: no stall, result visible one edge later.
  task automatic quick_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic fl,
                          input logic [31:0] hi, input logic [31:0] lo);
    push(name, hi, lo);
    drive(op, a, b, fl);
    @(negedge clock);
    chk({name, "_stall"}, {31'd0, StallMD}, 32'd0);
    observe();
  endtask

  task automatic div_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                        input int exp_stall);
    int n;
    logic got_done;
    n = 0; got_done = 1'b0;
    push(name, hi, lo);
    drive(op, a, b, 1'b0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (StallMD) n++;
      if (DoneE) begin got_done = 1'b1; break; end
      @(posedge clock); #1;
      idle_in();
    end
    chk({name, "_done"}, {31'd0, got_done}, 32'd1);
    chk({name, "_stallcycles"}, n, exp_stall);
    @(posedge clock); #1;
    idle_in();
    @(negedge clock);
  endtask

  // Monitor: HI/LO become visible the cycle after a DoneE pulse, or at a driver observe point.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (obs || done_d) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_result: got HI=0x%08h LO=0x%08h expected none", HiE, LoE);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_hi"}, HiE, e.hi);
          chk({e.name, "_lo"}, LoE, e.lo);
        end
      end
      done_d = DoneE;
      if (DoneE) done_cnt++;
    end
  end

  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_hi", HiE, 32'h0);
    chk("rst_lo", LoE, 32'h0);
    chk("rst_stall", {31'd0, StallMD}, 32'd0);
    chk("rst_done", {31'd0, DoneE}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    quick_op("mult", OP_MULT, 32'hFFFFFFFE, 32'd3, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFA);
    quick_op("multu", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001);
    div_op("div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33);

    // DIVU flushed at RUN counter=10: HI/LO keep the previous divide's result.
    push("flush_keep", 32'hFFFFFFFF, 32'hFFFFFFFD);
    drive(OP_DIVU, 32'd100, 32'd7, 1'b0);
    @(posedge clock); #1;
    idle_in();
    repeat (10) @(posedge clock);
    #1 FlushE = 1'b1;
    @(negedge clock);
    chk("flush_stall", {31'd0, StallMD}, 32'd0);
    chk("flush_done", {31'd0, DoneE}, 32'd0);
    observe();
    chk("flush_idle_stall", {31'd0, StallMD}, 32'd0);

    quick_op("mtlo", OP_MTLO, 32'h1234, 32'd0, 1'b0, 32'hFFFFFFFF, 32'h00001234);
    quick_op("mthi", OP_MTHI, 32'hABCD, 32'd0, 1'b0, 32'h0000ABCD, 32'h00001234);
    quick_op("op111", 3'b111, 32'h5555, 32'h7, 1'b0, 32'h0000ABCD, 32'h00001234);
    quick_op("mult_flushed", OP_MULT, 32'd9, 32'd9, 1'b1, 32'h0000ABCD, 32'h00001234);

    div_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 33);
    div_op("divu_5_0", OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, ZERO_STALL);
    div_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 33);
    div_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 33);

    // Reset mid-RUN clears HI/LO and drops the stall in the reset cycle.
    drive(OP_DIV, 32'd1000, 32'd3, 1'b0);
    @(posedge clock); #1;
    idle_in();
    repeat (5) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    chk("rst_mid_stall", {31'd0, StallMD}, 32'd0);
    push("rst_mid", 32'h0, 32'h0);
    @(posedge clock); #1;
    reset = 1'b0;
    obs = 1'b1;
    @(negedge clock); #1;
    obs = 1'b0;
    chk("rst_mid_idle_stall", {31'd0, StallMD}, 32'd0);

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("sb_empty", sb.size(), 32'd0);
    chk("done_pulses", done_cnt, 32'd5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
